// File: rtl/fetch_stage_pkg.sv
`default_nettype none
// =====================================================================
// fetch_stage_pkg : shared constants and encodings for the fetch stage
// Rev 1.0
// =====================================================================
package fetch_stage_pkg;

  localparam logic [31:0] PC_RESET_DEFAULT = 32'h0000_3000;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0000;

  // Encoding 2'b11 is reserved and resolves as "no branch".
  typedef enum logic [1:0] {
    BR_NONE = 2'b00,
    BR_BEQ  = 2'b01,
    BR_BNE  = 2'b10,
    BR_RSVD = 2'b11
  } br_type_e;

endpackage
`default_nettype wire

// File: rtl/fetch_stage_npc.sv
`default_nettype none
// =====================================================================
// fetch_stage_npc : combinational next-PC select (jr > j > branch > seq)
// Rev 1.0
// =====================================================================
module fetch_stage_npc
  import fetch_stage_pkg::*;
(
  input  logic [31:0] f_pc,
  input  logic [31:0] d_pc,
  input  logic [1:0]  d_br_type,
  input  logic        d_cmp_eq,
  input  logic        d_jump,
  input  logic        d_jr,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs_val,
  output logic [31:0] next_pc
);

  logic [31:0] w_d_pc_plus4;
  logic [31:0] w_br_tgt;
  logic [31:0] w_j_tgt;
  logic [31:0] w_seq_pc;
  br_type_e    w_br_kind;
  logic        w_taken;

  assign w_d_pc_plus4 = d_pc + 32'd4;
  assign w_br_tgt     = w_d_pc_plus4 + {{14{d_imm16[15]}}, d_imm16, 2'b00};
  assign w_j_tgt      = {w_d_pc_plus4[31:28], d_index26, 2'b00};
  assign w_seq_pc     = f_pc + 32'd4;
  assign w_br_kind    = br_type_e'(d_br_type);

  // d_cmp_eq arrives late in the cycle; keep it a single gate level from the mux.
  assign w_taken = ((w_br_kind == BR_BEQ) &&  d_cmp_eq) ||
                   ((w_br_kind == BR_BNE) && !d_cmp_eq);

  always_comb begin
    next_pc = w_seq_pc;
    if (d_jr) begin
      next_pc = d_rs_val;
    end else if (d_jump) begin
      next_pc = w_j_tgt;
    end else if (w_taken) begin
      next_pc = w_br_tgt;
    end
  end

endmodule
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// =====================================================================
// fetch_stage : PC register, next-PC select and IF/ID pipeline register
// Rev 1.0
// =====================================================================
module fetch_stage
  import fetch_stage_pkg::*;
#(
  parameter logic [31:0] PC_RESET = PC_RESET_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic [1:0]  d_br_type,
  input  logic        d_cmp_eq,
  input  logic        d_jump,
  input  logic        d_jr,
  input  logic [15:0] d_imm16,
  input  logic [25:0] d_index26,
  input  logic [31:0] d_rs_val,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] d_instr,
  output logic [31:0] d_pc,
  output logic [31:0] d_pc8
);

  logic [31:0] r_f_pc;
  logic [31:0] r_d_instr;
  logic [31:0] r_d_pc;
  logic [31:0] r_d_pc8;
  logic [31:0] w_next_pc;

  fetch_stage_npc u_npc (
    .f_pc      (r_f_pc),
    .d_pc      (r_d_pc),
    .d_br_type (d_br_type),
    .d_cmp_eq  (d_cmp_eq),
    .d_jump    (d_jump),
    .d_jr      (d_jr),
    .d_imm16   (d_imm16),
    .d_index26 (d_index26),
    .d_rs_val  (d_rs_val),
    .next_pc   (w_next_pc)
  );

  // The delay-slot instruction always enters IF/ID; a stall freezes PC and
  // IF/ID together so the held D instruction re-resolves once released.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_f_pc    <= PC_RESET;
      r_d_instr <= NOP_INSTR;
      r_d_pc    <= 32'h0;
      r_d_pc8   <= 32'h0;
    end else if (!stall) begin
      r_f_pc    <= w_next_pc;
      r_d_instr <= imem_rdata;
      r_d_pc    <= r_f_pc;
      r_d_pc8   <= r_f_pc + 32'd8;
    end
  end

  assign imem_addr = r_f_pc;
  assign d_instr   = r_d_instr;
  assign d_pc      = r_d_pc;
  assign d_pc8     = r_d_pc8;

endmodule
`default_nettype wire

// File: tb/tb_fetch_stage.sv
`default_nettype none
// =====================================================================
// tb_fetch_stage : randomized self-checking bench with a behavioural model
// Rev 1.0
// =====================================================================
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        stall;
  logic [1:0]  d_br_type;
  logic        d_cmp_eq;
  logic        d_jump;
  logic        d_jr;
  logic [15:0] d_imm16;
  logic [25:0] d_index26;
  logic [31:0] d_rs_val;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic [31:0] d_instr;
  logic [31:0] d_pc;
  logic [31:0] d_pc8;

  int n_vec = 0;
  int n_err = 0;

  // Behavioural model state
  logic [31:0] m_fpc, m_dinstr, m_dpc, m_dpc8;

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1234_5678;
  endfunction

  assign imem_rdata = mem_word(imem_addr);

  fetch_stage dut (
    .clk        (clk),
    .reset      (reset),
    .stall      (stall),
    .d_br_type  (d_br_type),
    .d_cmp_eq   (d_cmp_eq),
    .d_jump     (d_jump),
    .d_jr       (d_jr),
    .d_imm16    (d_imm16),
    .d_index26  (d_index26),
    .d_rs_val   (d_rs_val),
    .imem_addr  (imem_addr),
    .imem_rdata (imem_rdata),
    .d_instr    (d_instr),
    .d_pc       (d_pc),
    .d_pc8      (d_pc8)
  );

  // Next PC from the control-flow rules, using plain integer arithmetic.
  function automatic logic [31:0] ref_next();
    int off;
    logic [31:0] pc4;
    pc4 = m_dpc + 32'd4;
    if (d_jr) return d_rs_val;
    if (d_jump) return (pc4 & 32'hF000_0000) | (32'(d_index26) * 32'd4);
    if ((d_br_type == 2'd1 && d_cmp_eq) || (d_br_type == 2'd2 && !d_cmp_eq)) begin
      off = int'($signed(d_imm16)) * 4;
      return pc4 + 32'(off);
    end
    return m_fpc + 32'd4;
  endfunction

  task automatic model_reset();
    m_fpc = 32'h0000_3000; m_dinstr = 32'h0; m_dpc = 32'h0; m_dpc8 = 32'h0;
  endtask

  task automatic clear_ctrl();
    stall = 1'b0; d_br_type = 2'b00; d_cmp_eq = 1'b0; d_jump = 1'b0; d_jr = 1'b0;
    d_imm16 = 16'h0; d_index26 = 26'h0; d_rs_val = 32'h0;
  endtask

  // One clock edge; the model advances with the inputs as they stood before it.
  task automatic cyc();
    logic [31:0] nx;
    @(posedge clk);
    if (!stall) begin
      nx       = ref_next();
      m_dinstr = mem_word(m_fpc);
      m_dpc8   = m_fpc + 32'd8;
      m_dpc    = m_fpc;
      m_fpc    = nx;
    end
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_ctrl();
    reset = 1'b0;
    model_reset();
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    clear_ctrl();
    reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({imem_addr, d_instr, d_pc, d_pc8} !== {32'h3000, 32'h0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL reset_state: got %h/%h/%h/%h want 00003000/0/0/0", imem_addr, d_instr, d_pc, d_pc8);
    end
    @(negedge clk);
    reset = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cyc();
      n_vec++;
      if (imem_addr !== 32'h3000 + 32'(4 * i) || d_pc !== 32'h3000 + 32'(4 * (i - 1)) ||
          d_pc8 !== d_pc + 32'd8 || d_instr !== mem_word(d_pc)) begin
        n_err++;
        $display("FAIL seq_fetch%0d: got %h/%h/%h/%h want pc=%h", i, imem_addr, d_instr, d_pc, d_pc8, 32'h3000 + 32'(4 * i));
      end
    end
  endtask

  task automatic test_beq();
    do_reset();
    cyc();                         // d_pc=0x3000, f_pc=0x3004
    d_br_type = 2'b01; d_cmp_eq = 1'b1; d_imm16 = 16'h0003;
    cyc();
    n_vec++;
    if (imem_addr !== 32'h3010 || d_instr !== mem_word(32'h3004) || d_pc !== 32'h3004) begin
      n_err++;
      $display("FAIL beq_taken: got addr=%h instr=%h dpc=%h want 00003010/%h/00003004", imem_addr, d_instr, d_pc, mem_word(32'h3004));
    end
    d_cmp_eq = 1'b0;               // d_pc=0x3004 now, not taken
    cyc();
    n_vec++;
    if (imem_addr !== 32'h3014) begin
      n_err++;
      $display("FAIL beq_not_taken: got %h want 00003014", imem_addr);
    end
    clear_ctrl();
  endtask

  task automatic test_bne();
    do_reset();
    cyc();
    d_br_type = 2'b10; d_cmp_eq = 1'b1; d_imm16 = 16'h0040;
    cyc();
    n_vec++;
    if (imem_addr !== 32'h3008) begin
      n_err++;
      $display("FAIL bne_not_taken: got %h want 00003008", imem_addr);
    end
    clear_ctrl();
    cyc();                         // d_pc=0x3008, f_pc=0x300C
    d_br_type = 2'b10; d_cmp_eq = 1'b0; d_imm16 = 16'hFFFF;
    cyc();
    n_vec++;
    if (imem_addr !== 32'h3008 || d_pc !== 32'h300C) begin
      n_err++;
      $display("FAIL bne_neg_offset: got addr=%h dpc=%h want 00003008/0000300c", imem_addr, d_pc);
    end
    d_br_type = 2'b11; d_cmp_eq = 1'b0;   // reserved encoding is no branch
    cyc();
    n_vec++;
    if (imem_addr !== 32'h300C) begin
      n_err++;
      $display("FAIL br_reserved: got %h want 0000300c", imem_addr);
    end
    clear_ctrl();
  endtask

  task automatic test_jump();
    do_reset();
    cyc();
    d_jump = 1'b1; d_index26 = 26'h0000C03;
    d_br_type = 2'b01; d_cmp_eq = 1'b1; d_imm16 = 16'h0100;   // jump outranks branch
    cyc();
    n_vec++;
    if (imem_addr !== 32'h300C) begin
      n_err++;
      $display("FAIL jump_target: got %h want 0000300c", imem_addr);
    end
    clear_ctrl();
  endtask

  task automatic test_jr_stall();
    do_reset();
    cyc();                         // d_pc=0x3000, f_pc=0x3004
    d_jr = 1'b1; d_rs_val = 32'h0000_4000; d_jump = 1'b1; stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      cyc();
      n_vec++;
      if ({imem_addr, d_instr, d_pc, d_pc8} !== {32'h3004, mem_word(32'h3000), 32'h3000, 32'h3008}) begin
        n_err++;
        $display("FAIL jr_stall_hold%0d: got %h/%h/%h/%h want 00003004/%h/00003000/00003008", i, imem_addr, d_instr, d_pc, d_pc8, mem_word(32'h3000));
      end
    end
    stall = 1'b0;
    cyc();
    n_vec++;
    if (imem_addr !== 32'h4000 || d_pc !== 32'h3004) begin
      n_err++;
      $display("FAIL jr_release: got addr=%h dpc=%h want 00004000/00003004", imem_addr, d_pc);
    end
    clear_ctrl();
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 8; i++) cyc();
    n_vec++;
    if (imem_addr !== 32'h3020) begin
      n_err++;
      $display("FAIL pre_async_reset: got %h want 00003020", imem_addr);
    end
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    n_vec++;
    if ({imem_addr, d_instr, d_pc, d_pc8} !== {32'h3000, 32'h0, 32'h0, 32'h0}) begin
      n_err++;
      $display("FAIL async_reset: got %h/%h/%h/%h want 00003000/0/0/0", imem_addr, d_instr, d_pc, d_pc8);
    end
    @(negedge clk);
    reset = 1'b1;
    cyc();
    n_vec++;
    if (imem_addr !== 32'h3004 || d_pc !== 32'h3000) begin
      n_err++;
      $display("FAIL post_reset_fetch: got addr=%h dpc=%h want 00003004/00003000", imem_addr, d_pc);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    cyc();
    d_jr = 1'b1; d_rs_val = 32'hFFFF_FFFC;
    cyc();
    clear_ctrl();
    cyc();
    n_vec++;
    if (imem_addr !== 32'h0 || d_pc !== 32'hFFFF_FFFC || d_pc8 !== 32'h4) begin
      n_err++;
      $display("FAIL pc_wrap: got addr=%h dpc=%h dpc8=%h want 0/fffffffc/4", imem_addr, d_pc, d_pc8);
    end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      stall     = ($urandom_range(0, 3) == 0);
      d_br_type = 2'($urandom_range(0, 3));
      d_cmp_eq  = 1'($urandom_range(0, 1));
      d_jump    = ($urandom_range(0, 7) == 0);
      d_jr      = ($urandom_range(0, 7) == 0);
      d_imm16   = 16'($urandom);
      d_index26 = 26'($urandom);
      d_rs_val  = $urandom;
      cyc();
      n_vec++;
      if ({imem_addr, d_instr, d_pc, d_pc8} !== {m_fpc, m_dinstr, m_dpc, m_dpc8}) begin
        n_err++;
        $display("FAIL random%0d: got %h/%h/%h/%h want %h/%h/%h/%h", i, imem_addr, d_instr, d_pc, d_pc8, m_fpc, m_dinstr, m_dpc, m_dpc8);
      end
    end
    clear_ctrl();
  endtask

  initial begin
    reset = 1'b0;
    clear_ctrl();
    model_reset();
    test_reset();
    test_beq();
    test_bne();
    test_jump();
    test_jr_stall();
    test_async_reset();
    test_wrap();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
